// File: rtl/game_pkg.sv
// Shared types and defaults for the game datapath: physics step scheduler
// state encoding and per-frame sequencing constants.
package game_pkg;

  localparam int unsigned SCHED_NUM_CARS    = 2;
  localparam int unsigned SCHED_ROT_TIMEOUT = 64;

  // Legacy state encodings, kept stable so existing waveform decoders still match.
  localparam logic [2:0] SCHED_IDLE   = 3'd0;
  localparam logic [2:0] SCHED_REQ    = 3'd1;
  localparam logic [2:0] SCHED_WAIT   = 3'd2;
  localparam logic [2:0] SCHED_POS    = 3'd3;
  localparam logic [2:0] SCHED_COMMIT = 3'd4;
  localparam logic [2:0] SCHED_DONE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = SCHED_IDLE,
    ST_REQ    = SCHED_REQ,
    ST_WAIT   = SCHED_WAIT,
    ST_POS    = SCHED_POS,
    ST_COMMIT = SCHED_COMMIT,
    ST_DONE   = SCHED_DONE
  } sched_state_t;

endpackage

// File: rtl/physics_step_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_inc && (o_count != '1)) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/physics_step_scheduler.sv
// Per-frame sequencer: shares one rotator across all cars, strobes each car's
// position update, commits angle/velocity state, then signals frame done.
module physics_step_scheduler
  import game_pkg::*;
#(
  parameter int unsigned NUM_CARS      = SCHED_NUM_CARS,
  parameter int unsigned CAR_IDX_WIDTH = 1,
  parameter int unsigned ROT_TIMEOUT   = SCHED_ROT_TIMEOUT,
  parameter int unsigned OVR_CNT_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  input  logic                     i_frame_tick,
  input  logic                     i_rot_valid,
  input  logic                     i_clear_err,
  output logic                     o_rot_start,
  output logic [CAR_IDX_WIDTH-1:0] o_car_sel,
  output logic                     o_pos_we,
  output logic                     o_state_we,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_err_timeout,
  output logic [OVR_CNT_WIDTH-1:0] o_overrun_cnt
);

  localparam int unsigned TMO_WIDTH = (ROT_TIMEOUT > 1) ? $clog2(ROT_TIMEOUT) : 1;
  localparam logic [CAR_IDX_WIDTH-1:0] LAST_IDX = CAR_IDX_WIDTH'(NUM_CARS - 1);
  localparam logic [TMO_WIDTH-1:0]     TMO_LAST = TMO_WIDTH'(ROT_TIMEOUT - 1);

  sched_state_t             state_q, state_d;
  logic [CAR_IDX_WIDTH-1:0] idx_q, idx_d;
  logic [TMO_WIDTH-1:0]     tmo_q, tmo_d;
  logic                     tmo_hit;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_frame_tick && i_enable) begin
          state_d = ST_REQ;
          idx_d   = '0;
        end
      end
      ST_REQ: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the timeout cycle still counts as valid.
        if (i_rot_valid) begin
          state_d = ST_POS;
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d   = idx_q + CAR_IDX_WIDTH'(1);
            state_d = ST_REQ;
          end
        end else begin
          tmo_d = tmo_q + TMO_WIDTH'(1);
        end
      end
      ST_POS: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d   = idx_q + CAR_IDX_WIDTH'(1);
          state_d = ST_REQ;
        end
      end
      ST_COMMIT: state_d = ST_DONE;
      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from next-state so they line up with the state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      tmo_q         <= '0;
      o_rot_start   <= 1'b0;
      o_pos_we      <= 1'b0;
      o_state_we    <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      o_rot_start  <= (state_d == ST_REQ);
      o_pos_we     <= (state_d == ST_POS);
      o_state_we   <= (state_d == ST_COMMIT);
      o_busy       <= (state_d != ST_IDLE);
      o_frame_done <= (state_d == ST_DONE);
      if (i_clear_err) begin
        o_err_timeout <= 1'b0;
      end else if (tmo_hit) begin
        o_err_timeout <= 1'b1;
      end
    end
  end

  assign o_car_sel = idx_q;

  sat_counter #(
    .WIDTH(OVR_CNT_WIDTH)
  ) u_overrun_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_inc  (i_frame_tick && o_busy),
    .i_clr  (i_clear_err),
    .o_count(o_overrun_cnt)
  );

endmodule

// File: doc/physics_step_scheduler.md
Name: physics_step_scheduler

Overview:
- Per-frame sequencer for the car physics datapath. It time-shares one rotator instance across all cars, so there is no longer one RotateXY per car.
- On each frame tick it does the following, in order:
  - rotates each car's velocity magnitude by its heading;
  - strobes that car's position update;
  - commits angle and velocity state for all cars;
  - reports frame completion.
- It sits between the render-tick synchroniser and the car state/position register file.

Parameters:
- NUM_CARS, 2, number of cars sequenced per frame (1..4).
- CAR_IDX_WIDTH, 1, width of car select; must satisfy 2**CAR_IDX_WIDTH >= NUM_CARS.
- ROT_TIMEOUT, 64, cycles allowed in WAIT for rotator valid before abandoning that car.
- OVR_CNT_WIDTH, 8, width of the saturating overrun counter.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  when low, new frame ticks are ignored; a frame already in progress completes.
- i_frame_tick  in  1  one-cycle pulse per render frame, already synchronised to i_clk.
- i_rot_valid  in  1  rotator result valid for the current request.
- i_clear_err  in  1  clears o_err_timeout and o_overrun_cnt.
- o_rot_start  out  1  one-cycle rotator start pulse.
- o_car_sel  out  CAR_IDX_WIDTH  car whose v_m and angle feed the rotator, and whose position is written by o_pos_we.
- o_pos_we  out  1  one-cycle strobe: datapath performs x += v_x, y += v_y (with wrap) for car o_car_sel.
- o_state_we  out  1  one-cycle strobe: datapath commits angle and velocity-magnitude next-state for all cars.
- o_busy  out  1  high in every state except IDLE.
- o_frame_done  out  1  one-cycle pulse when the frame sequence ends.
- o_err_timeout  out  1  sticky; set when any rotator wait times out.
- o_overrun_cnt  out  OVR_CNT_WIDTH  saturating count of dropped ticks.

Behaviour:
- Reset: all outputs are 0, state is IDLE, car index is 0, timeout counter is 0. Reset is asynchronous, so asserting it mid-frame returns to IDLE immediately with no strobe.
- All strobes are Moore outputs, registered from state; no combinational path from inputs to outputs.
- States: IDLE, REQ, WAIT, POS, COMMIT, DONE.
- IDLE:
  - i_frame_tick=1 and i_enable=1: go to REQ with car index 0.
  - Otherwise: stay in IDLE.
- REQ (1 cycle): o_rot_start=1, o_car_sel=index; clear the timeout counter; go to WAIT.
- WAIT:
  - o_car_sel is held at the current index.
  - i_rot_valid=1: go to POS.
  - Else, timeout counter == ROT_TIMEOUT-1: set o_err_timeout and skip POS. Go to REQ for the next car, or to COMMIT if this was the last car.
  - Else: increment the timeout counter.
- POS (1 cycle): o_pos_we=1 for the current index. Then either increment the index and go to REQ, or, if index == NUM_CARS-1, go to COMMIT.
- COMMIT (1 cycle): o_state_we=1; go to DONE.
- DONE (1 cycle): o_frame_done=1; reset index to 0; go to IDLE.
- i_rot_valid outside WAIT is ignored. i_rot_valid in the same cycle as the timeout compare counts as a valid result: it goes to POS and does not set the error.
- Latency with a rotator that asserts valid 1 cycle after start:
  - tick in cycle 0;
  - REQ in cycle 1, POS in cycle 3 (car 0);
  - REQ in cycle 4, POS in cycle 6 (car 1);
  - COMMIT in cycle 7, DONE in cycle 8;
  - IDLE in cycle 9.
- General frame length: NUM_CARS*(2+L) + 2 cycles, where L is the number of cycles spent in WAIT.
- Overrun: i_frame_tick while o_busy=1 is dropped and increments o_overrun_cnt. The counter saturates at all-ones. A tick in DONE is also dropped.
- i_clear_err:
  - Zeroes both the error flag and the overrun counter, and takes priority over same-cycle set/increment.
  - Has no effect on state.
- i_enable going low mid-frame has no effect until IDLE.

Decomposition:
- game_pkg adds:
  - sched_state_t, an enum of the six states;
  - constants SCHED_NUM_CARS and SCHED_ROT_TIMEOUT.
- Overrun counter is a small sub-module sat_counter (width parameter, inc, clr inputs).
- FSM, index register and timeout counter stay in physics_step_scheduler.

Test Plan:
- Reset, then tick with the rotator model at L=1:
  - o_rot_start in cycles 1 and 4 (sel 0, then 1);
  - o_pos_we in cycles 3 and 6;
  - o_state_we in cycle 7, o_frame_done in cycle 8;
  - o_busy high in cycles 1–8.
- Rotator at L=5: frame_done 16 cycles after the tick; sel is stable through each WAIT.
- Rotator never valid for car 1, ROT_TIMEOUT=64:
  - car 0 gets pos_we, car 1 gets none;
  - o_err_timeout=1;
  - o_state_we is still issued, and the frame completes.
- Three ticks during one busy frame: o_overrun_cnt=3. With 300 dropped ticks and width 8: 255. i_clear_err then gives 0.
- i_enable=0 with a tick: no o_busy. i_enable deasserted in WAIT: the frame still completes with both pos_we strobes.
- i_rst_n pulled low in WAIT (car 1): all outputs 0 immediately. After release, the next tick restarts at sel 0.
